// File: rtl/immediate_extend_stage.sv
// ============================================================================
// immediate_extend_stage
// ----------------------------------------------------------------------------
// Registered immediate generator for the decode stage. Each accepted 32-bit
// instruction is classified by opcode (NONE/I/S/B/U/J) and its immediate is
// sign-extended to XLEN bits. A two-entry output buffer (main + skid) makes
// sure downstream backpressure never drops or duplicates an instruction.
// o_ready comes straight from a flop, so it never depends on i_ready in the
// same cycle.
//
// Parameters:
//   XLEN           output immediate width (32 or 64)
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_arst         asynchronous active-high reset
//   i_valid        upstream instruction valid
//   o_ready        stage can accept an instruction this cycle
//   i_instruction  raw RV32/RV64 base instruction
//   o_valid        output bundle valid
//   i_ready        downstream accepts the output bundle this cycle
//   o_instruction  instruction passed through, aligned with the immediate
//   o_immediate    sign-extended immediate (zero for NONE)
//   o_immType      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//
// Build option:
//   IMMEDIATE_EXTEND_UJ_EN  when defined, U and J formats are decoded.
//                           Otherwise their opcodes are classified NONE and
//                           the U/J immediate logic is not built.
// ============================================================================
module immediate_extend_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_arst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instruction,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instruction,
    output logic [XLEN-1:0] o_immediate,
    output logic [2:0]      o_immType
);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
`ifdef IMMEDIATE_EXTEND_UJ_EN
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
`endif

    // The buffer occupancy is the state: main only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [31:0]       main_inst_q, main_inst_d;
    logic [XLEN-1:0]   main_imm_q,  main_imm_d;
    logic [2:0]        main_type_q, main_type_d;

    logic [31:0]       skid_inst_q, skid_inst_d;
    logic [XLEN-1:0]   skid_imm_q,  skid_imm_d;
    logic [2:0]        skid_type_q, skid_type_d;

    logic [2:0]        dec_type;
    logic [31:0]       dec_imm32;
    logic [XLEN-1:0]   dec_imm;

    logic              in_fire;
    logic              out_fire;

    // Opcode classification and immediate assembly. Every format is built
    // as a 32-bit value whose bit 31 is inst[31]; the signed width cast
    // then replicates that bit up to XLEN-1. NONE yields a clean zero.
    always_comb begin
        dec_type  = TYPE_NONE;
        dec_imm32 = 32'd0;
        unique case (i_instruction[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_type  = TYPE_I;
                dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
            end
            7'b0100011: begin
                dec_type  = TYPE_S;
                dec_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25],
                             i_instruction[11:7]};
            end
            7'b1100011: begin
                dec_type  = TYPE_B;
                dec_imm32 = {{19{i_instruction[31]}}, i_instruction[31],
                             i_instruction[7], i_instruction[30:25],
                             i_instruction[11:8], 1'b0};
            end
`ifdef IMMEDIATE_EXTEND_UJ_EN
            7'b0110111, 7'b0010111: begin
                dec_type  = TYPE_U;
                dec_imm32 = {i_instruction[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_type  = TYPE_J;
                dec_imm32 = {{11{i_instruction[31]}}, i_instruction[31],
                             i_instruction[19:12], i_instruction[20],
                             i_instruction[30:21], 1'b0};
            end
`endif
            default: begin
                dec_type  = TYPE_NONE;
                dec_imm32 = 32'd0;
            end
        endcase
        dec_imm = XLEN'($signed(dec_imm32));
    end

    // Accepting is allowed whenever the skid slot is free; that is a pure
    // function of the registered state, which keeps o_ready registered.
    assign o_ready  = (state_q != ST_TWO);
    assign o_valid  = (state_q != ST_EMPTY);
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    // Next-state and buffer update. Main always holds the oldest entry; a
    // new entry goes to main only when main is free or being emptied this
    // cycle, otherwise it parks in skid. Draining from TWO promotes skid.
    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_imm_d  = main_imm_q;
        main_type_d = main_type_q;
        skid_inst_d = skid_inst_q;
        skid_imm_d  = skid_imm_q;
        skid_type_d = skid_type_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_inst_d = i_instruction;
                    main_imm_d  = dec_imm;
                    main_type_d = dec_type;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_inst_d = i_instruction;
                    main_imm_d  = dec_imm;
                    main_type_d = dec_type;
                end else if (in_fire) begin
                    skid_inst_d = i_instruction;
                    skid_imm_d  = dec_imm;
                    skid_type_d = dec_type;
                    state_d     = ST_TWO;
                end else if (out_fire) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_inst_d = skid_inst_q;
                    main_imm_d  = skid_imm_q;
                    main_type_d = skid_type_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and buffer registers; reset discards everything at once.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= '0;
            main_imm_q  <= '0;
            main_type_q <= TYPE_NONE;
            skid_inst_q <= '0;
            skid_imm_q  <= '0;
            skid_type_q <= TYPE_NONE;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_imm_q  <= main_imm_d;
            main_type_q <= main_type_d;
            skid_inst_q <= skid_inst_d;
            skid_imm_q  <= skid_imm_d;
            skid_type_q <= skid_type_d;
        end
    end

    assign o_instruction = main_inst_q;
    assign o_immediate   = main_imm_q;
    assign o_immType     = main_type_q;

endmodule
